// File: rtl/clock_set_ctrl_if.sv
// Button, current-time and shadow-time signals between the time-set controller
// and its neighbours (button conditioning, clock counters, display).
interface clock_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [1:0] cur_hours_p1;
    logic [3:0] cur_hours_p2;
    logic [2:0] cur_minutes_p1;
    logic [3:0] cur_minutes_p2;
    logic [1:0] set_hours_p1;
    logic [3:0] set_hours_p2;
    logic [2:0] set_minutes_p1;
    logic [3:0] set_minutes_p2;
    logic       load;
    logic       clk_hold;
    logic       blank_hr;
    logic       blank_min;
    logic [1:0] mode_state;

    modport master (
        output btn_mode, btn_inc, cur_hours_p1, cur_hours_p2, cur_minutes_p1, cur_minutes_p2,
        input  set_hours_p1, set_hours_p2, set_minutes_p1, set_minutes_p2,
               load, clk_hold, blank_hr, blank_min, mode_state
    );

    modport slave (
        input  btn_mode, btn_inc, cur_hours_p1, cur_hours_p2, cur_minutes_p1, cur_minutes_p2,
        output set_hours_p1, set_hours_p2, set_minutes_p1, set_minutes_p2,
               load, clk_hold, blank_hr, blank_min, mode_state
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// HH:MM time-set controller: mode/inc buttons walk hours then minutes in BCD,
// with auto-repeat, field blinking, idle timeout and a one-cycle commit load.
module clock_set_ctrl #(
    parameter logic [7:0]  HOLD_CYCLES    = 8'd200,
    parameter logic [7:0]  REPEAT_CYCLES  = 8'd50,
    parameter logic [7:0]  BLINK_HALF     = 8'd100,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd6000
) (
    input  logic            clk,
    input  logic            rst,
    clock_set_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        COMMIT  = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic        mode_q, inc_q;
    logic [1:0]  hr1_q, hr1_d;
    logic [3:0]  hr2_q, hr2_d;
    logic [2:0]  mn1_q, mn1_d;
    logic [3:0]  mn2_q, mn2_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  blink_q, blink_d;
    logic        phase_q, phase_d;
    logic [15:0] to_q, to_d;

    logic mode_rise, inc_rise, in_set, rep_evt, inc_evt, to_fire;
    logic hr_bad, min_bad;

    assign mode_rise = bus.btn_mode & ~mode_q;
    assign inc_rise  = bus.btn_inc & ~inc_q;
    assign in_set    = (state_q == SET_HR) || (state_q == SET_MIN);
    assign rep_evt   = in_set & bus.btn_inc & (hold_q == HOLD_CYCLES);
    assign inc_evt   = inc_rise | rep_evt;
    assign to_fire   = in_set & ~mode_rise & ~inc_rise & (to_q == TIMEOUT_CYCLES - 16'd1);

    assign hr_bad  = (bus.cur_hours_p2 > 4'd9) || (bus.cur_hours_p1 == 2'd3) ||
                     ((bus.cur_hours_p1 == 2'd2) && (bus.cur_hours_p2 > 4'd3));
    assign min_bad = (bus.cur_minutes_p1 > 3'd5) || (bus.cur_minutes_p2 > 4'd9);

    always_comb begin
        state_d = state_q;
        hr1_d   = hr1_q;
        hr2_d   = hr2_q;
        mn1_d   = mn1_q;
        mn2_d   = mn2_q;
        case (state_q)
            RUN: begin
                if (mode_rise) begin
                    state_d = SET_HR;
                    hr1_d   = hr_bad  ? 2'd0 : bus.cur_hours_p1;
                    hr2_d   = hr_bad  ? 4'd0 : bus.cur_hours_p2;
                    mn1_d   = min_bad ? 3'd0 : bus.cur_minutes_p1;
                    mn2_d   = min_bad ? 4'd0 : bus.cur_minutes_p2;
                end
            end
            SET_HR: begin
                if (mode_rise)    state_d = SET_MIN;
                else if (to_fire) state_d = RUN;
                else if (inc_evt) begin
                    if (hr1_q == 2'd2 && hr2_q == 4'd3) begin
                        hr1_d = 2'd0;
                        hr2_d = 4'd0;
                    end else if (hr2_q == 4'd9) begin
                        hr1_d = hr1_q + 2'd1;
                        hr2_d = 4'd0;
                    end else begin
                        hr2_d = hr2_q + 4'd1;
                    end
                end
            end
            SET_MIN: begin
                if (mode_rise)    state_d = COMMIT;
                else if (to_fire) state_d = RUN;
                else if (inc_evt) begin
                    if (mn2_q == 4'd9) begin
                        mn2_d = 4'd0;
                        mn1_d = (mn1_q == 3'd5) ? 3'd0 : mn1_q + 3'd1;
                    end else begin
                        mn2_d = mn2_q + 4'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Counters only run while staying in a set state; entry, exit and field
    // changes all restart them from zero with the blink phase visible.
    // The hold reload assumes REPEAT_CYCLES <= HOLD_CYCLES + 1.
    always_comb begin
        hold_d  = 8'd0;
        blink_d = 8'd0;
        phase_d = 1'b0;
        to_d    = 16'd0;
        if (in_set && (state_d == state_q)) begin
            if (bus.btn_inc)
                hold_d = rep_evt ? (HOLD_CYCLES - REPEAT_CYCLES + 8'd1) : (hold_q + 8'd1);
            if (blink_q == BLINK_HALF - 8'd1) begin
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 8'd1;
                phase_d = phase_q;
            end
            if (!(mode_rise || inc_rise))
                to_d = to_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            mode_q  <= 1'b0;
            inc_q   <= 1'b0;
            hr1_q   <= '0;
            hr2_q   <= '0;
            mn1_q   <= '0;
            mn2_q   <= '0;
            hold_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= bus.btn_mode;
            inc_q   <= bus.btn_inc;
            hr1_q   <= hr1_d;
            hr2_q   <= hr2_d;
            mn1_q   <= mn1_d;
            mn2_q   <= mn2_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            to_q    <= to_d;
        end
    end

    assign bus.set_hours_p1   = hr1_q;
    assign bus.set_hours_p2   = hr2_q;
    assign bus.set_minutes_p1 = mn1_q;
    assign bus.set_minutes_p2 = mn2_q;
    assign bus.load           = (state_q == COMMIT);
    assign bus.clk_hold       = (state_q != RUN);
    assign bus.blank_hr       = (state_q == SET_HR) & phase_q & ~bus.btn_inc;
    assign bus.blank_min      = (state_q == SET_MIN) & phase_q & ~bus.btn_inc;
    assign bus.mode_state     = state_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: integer-time reference model predicts
// every cycle's outputs plus each commit's load value.
module tb_clock_set_ctrl;
    localparam logic [7:0]  HOLD = 8'd8;
    localparam logic [7:0]  REP  = 8'd4;
    localparam logic [7:0]  BLK  = 8'd4;
    localparam logic [15:0] TO   = 16'd64;

    typedef struct packed {
        logic [1:0]  st;
        logic [12:0] set;
        logic        load;
        logic        hold;
        logic        bhr;
        logic        bmin;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .BLINK_HALF    (BLK),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t        exp_q[$];
    logic [12:0] load_q[$];
    int tests = 0;
    int fails = 0;

    // reference model state: time held as plain integers
    int m_st, m_h, m_m, k, since, idle;
    bit pm, pi;
    int c_h1, c_h2, c_m1, c_m2;

    function automatic logic [12:0] pack_time(int h, int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic void model_step(bit r, bit md, bit ic);
        exp_t e;
        int nst, hv;
        bit rm, ri, ins, rep, ev, fire;
        if (!r) begin
            m_st = 0; m_h = 0; m_m = 0; k = 0; since = 0; idle = 0; pm = 0; pi = 0;
        end else begin
            rm   = md & ~pm;
            ri   = ic & ~pi;
            ins  = (m_st == 1) || (m_st == 2);
            rep  = ins && ic && (k >= int'(HOLD)) && (((k - int'(HOLD)) % int'(REP)) == 0);
            ev   = ri | rep;
            fire = ins && !rm && !ri && (idle + 1 == int'(TO));
            nst  = m_st;
            case (m_st)
                0: if (rm) begin
                    nst = 1;
                    hv  = c_h1 * 10 + c_h2;
                    m_h = (c_h2 > 9 || hv > 23) ? 0 : hv;
                    m_m = (c_m1 > 5 || c_m2 > 9) ? 0 : c_m1 * 10 + c_m2;
                end
                1: if (rm) nst = 2; else if (fire) nst = 0; else if (ev) m_h = (m_h + 1) % 24;
                2: if (rm) nst = 3; else if (fire) nst = 0; else if (ev) m_m = (m_m + 1) % 60;
                default: nst = 0;
            endcase
            if (ins && nst == m_st) begin
                k     = ic ? k + 1 : 0;
                since = since + 1;
                idle  = (rm || ri) ? 0 : idle + 1;
            end else begin
                k = 0; since = 0; idle = 0;
            end
            m_st = nst; pm = md; pi = ic;
        end
        e.st   = 2'(m_st);
        e.set  = pack_time(m_h, m_m);
        e.load = (m_st == 3);
        e.hold = (m_st != 0);
        e.bhr  = (m_st == 1) && (((since / int'(BLK)) % 2) == 1) && !ic;
        e.bmin = (m_st == 2) && (((since / int'(BLK)) % 2) == 1) && !ic;
        exp_q.push_back(e);
        if (e.load) load_q.push_back(e.set);
    endfunction

    task automatic cyc(input bit r, input bit md, input bit ic);
        @(negedge clk);
        rst                = r;
        bus.btn_mode       = md;
        bus.btn_inc        = ic;
        bus.cur_hours_p1   = 2'(c_h1);
        bus.cur_hours_p2   = 4'(c_h2);
        bus.cur_minutes_p1 = 3'(c_m1);
        bus.cur_minutes_p2 = 4'(c_m2);
        model_step(r, md, ic);
    endtask

    task automatic setc(input int h1, input int h2, input int m1, input int m2);
        c_h1 = h1; c_h2 = h2; c_m1 = m1; c_m2 = m2;
    endtask

    task automatic mode_pulse();
        cyc(1, 1, 0);
        cyc(1, 0, 0);
    endtask

    task automatic inc_pulse();
        cyc(1, 0, 1);
        cyc(1, 0, 0);
    endtask

    // monitor: one snapshot per cycle, plus a load check whenever the DUT strobes
    initial begin
        exp_t        e, a;
        logic [12:0] ls, aset;
        forever begin
            @(posedge clk);
            #1;
            aset = {bus.set_hours_p1, bus.set_hours_p2, bus.set_minutes_p1, bus.set_minutes_p2};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{st: bus.mode_state, set: aset, load: bus.load, hold: bus.clk_hold,
                      bhr: bus.blank_hr, bmin: bus.blank_min};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL snapshot t=%0t: actual st=%b set=%h load=%b hold=%b bhr=%b bmin=%b, required st=%b set=%h load=%b hold=%b bhr=%b bmin=%b",
                             $time, a.st, a.set, a.load, a.hold, a.bhr, a.bmin,
                             e.st, e.set, e.load, e.hold, e.bhr, e.bmin);
                end
            end
            if (bus.load === 1'b1) begin
                tests++;
                if (load_q.size() == 0) begin
                    fails++;
                    $display("FAIL load_strobe t=%0t: actual load with set=%h, required no load", $time, aset);
                end else begin
                    ls = load_q.pop_front();
                    if (aset !== ls) begin
                        fails++;
                        $display("FAIL load_value t=%0t: actual %h, required %h", $time, aset, ls);
                    end
                end
            end
        end
    end

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        setc(0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0);

        // basic set 12:34 -> 15:04
        setc(1, 2, 3, 4);
        cyc(1, 0, 0);
        mode_pulse();
        repeat (3) inc_pulse();
        mode_pulse();
        repeat (30) inc_pulse();
        mode_pulse();
        repeat (3) cyc(1, 0, 0);

        // wrap 22:58 -> 00:00, then invalid capture 25:70 -> 00:00 and commit
        setc(2, 2, 5, 8);
        mode_pulse();
        repeat (2) inc_pulse();
        mode_pulse();
        repeat (2) inc_pulse();
        mode_pulse();
        cyc(1, 0, 0);
        setc(2, 5, 7, 0);
        mode_pulse();
        mode_pulse();
        mode_pulse();
        cyc(1, 0, 0);

        // auto-repeat from 00: edge + five repeats -> 06
        setc(0, 0, 0, 0);
        mode_pulse();
        repeat (28) cyc(1, 0, 1);
        cyc(1, 0, 0);

        // blink in SET_MIN then idle timeout, no load
        mode_pulse();
        repeat (70) cyc(1, 0, 0);

        // mode and inc rise together: mode wins
        mode_pulse();
        cyc(1, 1, 1);
        cyc(1, 0, 0);
        // reset mid-set aborts
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        // buttons held across reset give one rise each after release
        cyc(0, 1, 1);
        cyc(1, 1, 1);
        repeat (3) cyc(1, 0, 0);

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            bit md, ic, r;
            md = bus.btn_mode;
            ic = bus.btn_inc;
            if ($urandom_range(0, 99) < 8)  md = ~md;
            if ($urandom_range(0, 99) < 12) ic = ~ic;
            r = ($urandom_range(0, 499) != 0);
            setc($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15));
            if ((n % 500) == 250) begin
                repeat (70) cyc(1, md, ic);
            end else begin
                cyc(r, md, ic);
            end
        end
        repeat (4) cyc(1, 0, 0);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
        tests++;
        if (exp_q.size() != 0 || load_q.size() != 0) begin
            fails++;
            $display("FAIL drain: actual %0d snapshots and %0d loads pending, required 0 and 0",
                     exp_q.size(), load_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
